// File: rtl/trig_pulse_arbiter.sv
// trig_pulse_arbiter
// Shares one downstream trigger port between NCH edge-detect channels.
// Each channel holds one pending event. Grants are round-robin, and a
// programmable dead time follows every accepted trigger. The block also
// holds the per-channel veto-last masks and drives the detector valid gates.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no trigger offered; grant the next pending channel if any
//   S_OFFER | trig_valid high, trig_ch stable, waiting for trig_ready
//   S_DEAD  | post-trigger dead time; dcnt counts down to 1, then S_IDLE
module trig_pulse_arbiter #(
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int DEADW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       pulse_in,
  input  logic [NCH-1:0]       enable,
  input  logic                 run,
  input  logic [DEADW-1:0]     deadtime,
  input  logic                 cfg_wr,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [2:0]           cfg_veto,
  output logic [3*NCH-1:0]     veto_last,
  output logic [NCH-1:0]       valid_out,
  output logic                 trig_valid,
  output logic [CHW-1:0]       trig_ch,
  input  logic                 trig_ready,
  output logic [NCH-1:0]       pending,
  output logic [15:0]          trig_count,
  output logic [15:0]          drop_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t           state;
  logic [CHW-1:0]   rr_ptr;
  logic [DEADW-1:0] dcnt;

  logic [NCH-1:0]   new_ev;
  logic [NCH-1:0]   upper_mask;
  logic [NCH-1:0]   hi_req;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   drops;
  logic [CHW-1:0]   sel_ch;
  logic [CHW-1:0]   next_ptr;
  logic             grant;
  logic [4:0]       n_drops;
  logic [16:0]      drop_sum;

  assign valid_out = enable & {NCH{run}};
  assign new_ev    = pulse_in & enable & {NCH{run}};

  // Grant only from IDLE, and only on events already registered in pending;
  // pulses arriving this cycle become eligible next cycle.
  assign grant = (state == S_IDLE) && (|pending);

  // Round-robin pick: lowest pending channel at or above rr_ptr, otherwise
  // wrap and take the lowest pending channel overall.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      upper_mask[i] = (CHW'(i) >= rr_ptr);
    end
    hi_req = pending & upper_mask;
    sel_ch = '0;
    if (|hi_req) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (hi_req[i]) sel_ch = CHW'(i);
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (pending[i]) sel_ch = CHW'(i);
      end
    end
  end

  // One-hot clear for the channel granted this cycle, plus per-channel drops.
  // A pulse on the channel being granted re-arms pending instead of dropping.
  always_comb begin
    clr     = '0;
    n_drops = '0;
    for (int i = 0; i < NCH; i++) begin
      clr[i] = grant && (sel_ch == CHW'(i));
    end
    drops = new_ev & pending & ~clr;
    for (int i = 0; i < NCH; i++) begin
      n_drops = n_drops + 5'(drops[i]);
    end
    drop_sum = {1'b0, drop_count} + 17'(n_drops);
  end

  // The pointer moves past the channel just accepted, wrapping at NCH-1.
  assign next_ptr = (trig_ch == CHW'(NCH - 1)) ? '0 : trig_ch + CHW'(1);

  // Pending flags and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      drop_count <= '0;
    end else begin
      pending <= (pending & ~clr) | new_ev;
      if (drop_sum[16]) begin
        drop_count <= 16'hFFFF;
      end else begin
        drop_count <= drop_sum[15:0];
      end
    end
  end

  // Arbitration FSM with registered trigger outputs and dead-time counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      trig_valid <= 1'b0;
      trig_ch    <= '0;
      rr_ptr     <= '0;
      dcnt       <= '0;
      trig_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            trig_valid <= 1'b1;
            trig_ch    <= sel_ch;
            state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (trig_ready) begin
            trig_valid <= 1'b0;
            trig_count <= trig_count + 16'd1;
            rr_ptr     <= next_ptr;
            if (deadtime == '0) begin
              state <= S_IDLE;
            end else begin
              dcnt  <= deadtime;
              state <= S_DEAD;
            end
          end
        end
        S_DEAD: begin
          // Terminal count at 1 so D cycles of dead time precede the next grant.
          if (dcnt <= DEADW'(1)) begin
            dcnt  <= '0;
            state <= S_IDLE;
          end else begin
            dcnt <= dcnt - DEADW'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          trig_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel veto masks; an out-of-range channel index matches no slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      veto_last <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_ch == CHW'(i)) veto_last[3*i +: 3] <= cfg_veto;
      end
    end
  end

endmodule

// File: tb/tb_trig_pulse_arbiter.sv
// Directed bench for trig_pulse_arbiter. Expected trigger channels are queued
// when pulses are driven and popped by a monitor at each observed handshake.
module tb_trig_pulse_arbiter;
  localparam int NCH   = 4;
  localparam int CHW   = 3;
  localparam int DEADW = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH-1:0]     pulse_in;
  logic [NCH-1:0]     enable;
  logic               run;
  logic [DEADW-1:0]   deadtime;
  logic               cfg_wr;
  logic [CHW-1:0]     cfg_ch;
  logic [2:0]         cfg_veto;
  logic [3*NCH-1:0]   veto_last;
  logic [NCH-1:0]     valid_out;
  logic               trig_valid;
  logic [CHW-1:0]     trig_ch;
  logic               trig_ready;
  logic [NCH-1:0]     pending;
  logic [15:0]        trig_count;
  logic [15:0]        drop_count;

  int total = 0;
  int bad   = 0;
  int sb[$];
  int mon_exp;

  trig_pulse_arbiter #(.NCH(NCH), .CHW(CHW), .DEADW(DEADW)) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .enable     (enable),
    .run        (run),
    .deadtime   (deadtime),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_veto   (cfg_veto),
    .veto_last  (veto_last),
    .valid_out  (valid_out),
    .trig_valid (trig_valid),
    .trig_ch    (trig_ch),
    .trig_ready (trig_ready),
    .pending    (pending),
    .trig_count (trig_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // A handshake happens at the next rising edge when valid and ready are both
  // high here and reset is low; the offered channel must be the oldest queued.
  always @(negedge clk) begin
    if (!reset && trig_valid && trig_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("trig_ch_order", 32'(trig_ch), 32'(mon_exp));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    pulse_in   = 4'hF;
    enable     = 4'hF;
    run        = 1'b1;
    deadtime   = '0;
    cfg_wr     = 1'b0;
    cfg_ch     = '0;
    cfg_veto   = '0;
    trig_ready = 1'b0;

    // Reset held 3 cycles with pulses present: everything stays cleared.
    ticks(3);
    check("rst_trig_valid", 32'(trig_valid), 32'd0);
    check("rst_pending",    32'(pending),    32'd0);
    check("rst_trig_count", 32'(trig_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_veto_last",  32'(veto_last),  32'd0);
    check("rst_trig_ch",    32'(trig_ch),    32'd0);
    reset    = 1'b0;
    pulse_in = '0;
    ticks(4);
    check("idle_trig_valid", 32'(trig_valid), 32'd0);
    check("idle_pending",    32'(pending),    32'd0);

    // Latency: pulse ch2 sampled at edge N, grant at N+1, handshake at N+2.
    trig_ready = 1'b1;
    pulse_in = 4'b0100; sb.push_back(2);
    tick(); pulse_in = '0;
    check("lat_pending",     32'(pending),    32'h4);
    check("lat_valid_early", 32'(trig_valid), 32'd0);
    tick();
    check("lat_valid",       32'(trig_valid), 32'd1);
    check("lat_ch",          32'(trig_ch),    32'd2);
    check("lat_pending_clr", 32'(pending),    32'd0);
    tick();
    check("lat_valid_hs",    32'(trig_valid), 32'd0);
    check("lat_count",       32'(trig_count), 32'd1);

    // ch3 alone moves rr_ptr back to 0.
    pulse_in = 4'b1000; sb.push_back(3);
    tick(); pulse_in = '0;
    ticks(3);
    check("rr_prep_count", 32'(trig_count), 32'd2);

    // Round-robin over ch0, ch1, ch3; one grant every 2 cycles.
    pulse_in = 4'b1011; sb.push_back(0); sb.push_back(1); sb.push_back(3);
    tick(); pulse_in = '0;
    tick();
    check("rr_first_ch",  32'(trig_ch),    32'd0);
    ticks(2);
    check("rr_second_v",  32'(trig_valid), 32'd1);
    check("rr_second_ch", 32'(trig_ch),    32'd1);
    ticks(2);
    check("rr_third_ch",  32'(trig_ch),    32'd3);
    tick();
    check("rr_count",     32'(trig_count), 32'd5);
    check("rr_idle",      32'(trig_valid), 32'd0);

    // rr_ptr wrapped to 0, so ch0 wins over ch3.
    pulse_in = 4'b1001; sb.push_back(0); sb.push_back(3);
    tick(); pulse_in = '0;
    tick();
    check("wrap_first_ch", 32'(trig_ch), 32'd0);
    ticks(4);
    check("wrap_count",    32'(trig_count), 32'd7);
    check("wrap_idle",     32'(trig_valid), 32'd0);

    // Backpressure: ch1 offered; three more ch1 pulses give 1 re-arm + 2 drops.
    trig_ready = 1'b0;
    pulse_in = 4'b0010; sb.push_back(1);
    tick(); pulse_in = '0;
    tick();
    check("bp_offer_v",  32'(trig_valid), 32'd1);
    check("bp_offer_ch", 32'(trig_ch),    32'd1);
    pulse_in = 4'b0010; sb.push_back(1);
    tick(); pulse_in = '0;
    tick(); pulse_in = 4'b0010;
    tick(); pulse_in = '0;
    tick(); pulse_in = 4'b0010;
    tick(); pulse_in = '0;
    check("bp_drops",   32'(drop_count), 32'd2);
    check("bp_hold_ch", 32'(trig_ch),    32'd1);
    check("bp_hold_v",  32'(trig_valid), 32'd1);
    check("bp_pending", 32'(pending),    32'h2);
    trig_ready = 1'b1;
    tick(); trig_ready = 1'b0;
    check("bp_one_accept", 32'(trig_count), 32'd8);
    check("bp_valid_low",  32'(trig_valid), 32'd0);
    tick();
    check("bp_regrant_v",  32'(trig_valid), 32'd1);
    check("bp_regrant_ch", 32'(trig_ch),    32'd1);
    check("bp_count_held", 32'(trig_count), 32'd8);
    trig_ready = 1'b1;
    tick();
    check("bp_count_final", 32'(trig_count), 32'd9);
    tick();

    // Dead time 5: handshake at H, ch0 pulse at H+1, next grant at H+6.
    deadtime = 8'd5;
    pulse_in = 4'b0001; sb.push_back(0);
    tick(); pulse_in = '0;
    ticks(2);
    check("dt_hs_count", 32'(trig_count), 32'd10);
    pulse_in = 4'b0001; sb.push_back(0);
    tick(); pulse_in = '0;
    for (int k = 0; k < 5; k++) begin
      check("dt_hold_low", 32'(trig_valid), 32'd0);
      tick();
    end
    check("dt_regrant_v",  32'(trig_valid), 32'd1);
    check("dt_regrant_ch", 32'(trig_ch),    32'd0);
    tick();
    check("dt_count", 32'(trig_count), 32'd11);
    trig_ready = 1'b0;
    ticks(7);
    check("dt_idle_v",   32'(trig_valid), 32'd0);
    check("dt_idle_pnd", 32'(pending),    32'd0);

    // Drop saturation: all channels pulsing while stalled in OFFER on ch1.
    // 2 earlier + 3 on the grant edge + 4 per following edge.
    deadtime = '0;
    pulse_in = 4'hF;
    ticks(16384);
    check("sat_pre",     32'(drop_count), 32'd65533);
    check("sat_pending", 32'(pending),    32'hF);
    check("sat_offer_v", 32'(trig_valid), 32'd1);
    check("sat_offer_ch",32'(trig_ch),    32'd1);
    tick();
    check("sat_clamp", 32'(drop_count), 32'd65535);
    tick();
    check("sat_hold",  32'(drop_count), 32'd65535);
    pulse_in = '0;

    // Configuration writes during OFFER.
    cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_veto = 3'b101;
    tick(); cfg_wr = 1'b0;
    check("cfg_ch3_slice", 32'(veto_last[11:9]), 32'h5);
    check("cfg_ch3_all",   32'(veto_last),       32'hA00);
    cfg_wr = 1'b1; cfg_ch = 3'd4; cfg_veto = 3'b111;
    tick(); cfg_wr = 1'b0;
    check("cfg_oob", 32'(veto_last), 32'hA00);
    cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_veto = 3'b011;
    tick(); cfg_wr = 1'b0;
    check("cfg_ch0",      32'(veto_last),  32'hA03);
    check("cfg_offer_v",  32'(trig_valid), 32'd1);

    // Gates: valid_out is combinational; dropping enable/run keeps state.
    enable = '0; run = 1'b0; #1;
    check("vo_off", 32'(valid_out), 32'd0);
    tick();
    check("en_keep_pending", 32'(pending),    32'hF);
    check("en_keep_offer",   32'(trig_valid), 32'd1);
    enable = 4'b0101; run = 1'b1; #1;
    check("vo_mask", 32'(valid_out), 32'h5);
    run = 1'b0; #1;
    check("vo_run_off", 32'(valid_out), 32'd0);
    run = 1'b1; enable = 4'hF;

    // Reset during OFFER clears every register output.
    reset = 1'b1; pulse_in = 4'hF;
    tick();
    check("rmo_valid",  32'(trig_valid), 32'd0);
    check("rmo_veto",   32'(veto_last),  32'd0);
    check("rmo_pend",   32'(pending),    32'd0);
    check("rmo_drop",   32'(drop_count), 32'd0);
    check("rmo_count",  32'(trig_count), 32'd0);
    check("rmo_ch",     32'(trig_ch),    32'd0);
    reset = 1'b0; pulse_in = '0;

    // rr_ptr back at 0 after reset: ch1 then ch2.
    trig_ready = 1'b1;
    pulse_in = 4'b0110; sb.push_back(1); sb.push_back(2);
    tick(); pulse_in = '0;
    ticks(5);
    check("post_rst_count", 32'(trig_count), 32'd2);
    check("sb_drained",     32'(sb.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trig_pulse_arbiter.md
# trig_pulse_arbiter

Collects the clk-domain one-cycle pulses produced by NCH edge-detect-with-veto channels and shares a single downstream trigger port between them. Each channel holds one pending event; grants are round-robin, then a programmable dead time blocks further grants. The block also owns the per-channel configuration those detectors consume: the 3-bit veto-last mask and the valid/arm gate.

## Interface
- NCH, 4: number of pulse channels (2..16).
- CHW, 2: width of a channel index; must satisfy 2^CHW ≥ NCH.
- DEADW, 8: width of the dead-time counter.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pulse_in  in  NCH  one-cycle pulses from the edge detectors, already synchronous to clk.
- enable  in  NCH  per-channel enable; a pulse on a disabled channel is ignored.
- run  in  1  global arm.
- deadtime  in  DEADW  cycles of dead time after each accepted trigger; 0 means no dead time.
- cfg_wr  in  1  one-cycle strobe that writes a veto mask.
- cfg_ch  in  CHW  channel selected by cfg_wr.
- cfg_veto  in  3  veto mask to write.
- veto_last  out  3*NCH  per-channel veto masks; bits [3i+2:3i] belong to channel i; reset 0.
- valid_out  out  NCH  valid gate to each detector, equal to enable & {NCH{run}} (combinational).
- trig_valid  out  1  a trigger is offered downstream; reset 0.
- trig_ch  out  CHW  channel of the offered trigger; reset 0.
- trig_ready  in  1  downstream accepts the offered trigger.
- pending  out  NCH  per-channel pending flags; reset 0.
- trig_count  out  16  accepted triggers, wraps at 65535→0; reset 0.
- drop_count  out  16  dropped pulses, saturates at 65535; reset 0.

## Operation
- **Event capture**
  - A new event on channel i is `new[i] = pulse_in[i] & enable[i] & run`.
  - Each cycle: `pending <= (pending & ~clr) | new`, where `clr` is the one-hot grant issued in that cycle (otherwise 0).
- **Drop rule**
  - A drop occurs for channel i when `new[i] & pending[i] & ~clr[i]`.
  - drop_count adds the number of drops in the cycle, saturating.
  - A pulse that lands on the channel being granted in the same cycle is not a drop; it re-sets pending.
- **FSM: IDLE, OFFER, DEAD.** Reset state is IDLE.
  - **IDLE:** if pending is nonzero, select the first set bit scanning from rr_ptr upward with wrap-around, at or after rr_ptr.
    - Load trig_ch with that channel, assert clr for it, go to OFFER.
    - Events captured this cycle are not eligible until the next cycle.
  - **OFFER:** hold trig_valid=1 with trig_ch stable until trig_ready=1. On handshake:
    - trig_count increments;
    - rr_ptr becomes trig_ch+1, wrapping from NCH-1 to 0;
    - if deadtime=0, go to IDLE; otherwise load dcnt=deadtime and go to DEAD.
  - **DEAD:** dcnt decrements each cycle; when dcnt=1, go to IDLE. Capture and drop logic stay active.
- rr_ptr resets to 0.
- **Configuration**
  - When cfg_wr=1, the slice for cfg_ch in veto_last takes cfg_veto at the next edge.
  - cfg_ch ≥ NCH is ignored.
  - Writes are allowed in any FSM state.
- Changing enable or run never clears pending or aborts OFFER.

## Timing
- pulse_in sampled at edge N → pending set after N.
- Grant at edge N+1, with trig_valid=1 after N+1. Minimum pulse-to-trig_valid latency is 2 cycles.
- If trig_ready is already high, the handshake completes at edge N+2.
- After a handshake at edge H with deadtime=D>0, the next grant occurs no earlier than edge H+D+1. trig_valid is then high again after that edge.
- With D=0, back-to-back grants give one trigger per 2 cycles.
- Registered outputs change only on clk edges.
- **Reset**
  - A high reset sampled at edge R returns every register output to its reset value after R, including during OFFER or DEAD.
  - Pulses arriving during reset are discarded.
  - valid_out follows its inputs combinationally.

## Test plan
- Reset/idle: hold reset 3 cycles with pulse_in=4'hF.
  - Expect trig_valid, pending, trig_count, drop_count and veto_last all 0.
  - Expect no trigger after reset is released.
- Latency: run=1, enable=4'hF, trig_ready=1, deadtime=0, single pulse on ch2 at edge 10.
  - Expect pending[2] after 10, trig_valid with trig_ch=2 after edge 11, handshake at 12.
  - Expect trig_count=1.
- Round-robin: pulses on ch0, ch1 and ch3 in the same cycle, trig_ready=1, deadtime=0.
  - Expect grants in order 0, 1, 3.
  - Then a simultaneous ch0+ch3 pulse is granted 0 first, since rr_ptr wrapped to 0.
- Backpressure/drop: trig_ready=0; pulse ch1 three times while ch1 is pending and not being granted.
  - Expect drop_count=2, trig_ch held at 1.
  - Raise trig_ready and expect exactly 1 accepted trigger.
- Dead time: deadtime=5, handshake at edge H, ch0 pulse at H+1.
  - Expect trig_valid low through edge H+5 and high after H+6.
  - Drop saturation: force 65537 drops; expect drop_count=65535.
- Config/reset mid-offer:
  - Write cfg_ch=3, cfg_veto=3'b101; expect veto_last[11:9]=3'b101.
  - Write cfg_ch≥NCH (e.g. 3'd4 with CHW=3, NCH=4); expect no change.
  - Assert reset during OFFER; expect trig_valid=0 after that edge and veto_last cleared.
